matrix_3x3_gen: RTL and testbench
=================================

Name: matrix_3x3_gen

Overview:
Builds a 3x3 pixel neighbourhood from a raster DVP pixel stream, for the VP filter stages (Sobel, median, Gaussian).
- Two line delays hold the two previous rows.
- Three 3-tap shift registers form the window.
- Outputs are zero-padded at the top and left frame borders.
- Outputs a delayed href/vsync aligned with the window.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 1280, active pixels per line (href-high cycles per line)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
pre_vsync  in  1  frame sync, active-high; rising edge marks frame start
pre_href  in  1  line valid; high for exactly IMG_WIDTH contiguous cycles per line
pre_data  in  DATA_WIDTH  pixel, valid when pre_href=1
post_vsync  out  1  pre_vsync delayed 2 cycles
post_href  out  1  pre_href delayed 2 cycles
p11,p12,p13  out  DATA_WIDTH each  top row (y-2), columns x-2, x-1, x
p21,p22,p23  out  DATA_WIDTH each  middle row (y-1), columns x-2, x-1, x
p31,p32,p33  out  DATA_WIDTH each  bottom row (y), columns x-2, x-1, x

Behaviour:
- Reset: all outputs 0; href/vsync pipelines, line counter and line-delay pointers are 0. RAM contents are not reset; don't-care because of gating.
- Stage 1 (on pre_href=1):
  - row3_tap <= pre_data.
  - line delay A takes pre_data; its registered output is the sample written exactly IMG_WIDTH enabled cycles earlier.
  - line delay B takes A's output and delays it another IMG_WIDTH.
  - row2_tap = A output; row1_tap = B output.
  - Taps hold when pre_href=0.
- Line counter line_cnt (2 bits, saturates at 2):
  - Cleared to 0 on a pre_vsync rising edge, also mid-line.
  - Incremented on each pre_href falling edge.
  - Gating: row2 tap forced 0 while line_cnt<1; row1 tap forced 0 while line_cnt<2.
- Stage 2:
  - href_d1/vsync_d1 are 1-cycle delays of the inputs.
  - When href_d1=1: p13<=row1, p12<=p13, p11<=p12; same pattern for rows 2 and 3.
  - When href_d1=0: all nine window registers cleared to 0, so the first pixel of each line sees zero in columns x-1 and x-2.
- Latency: the sample entered at cycle t appears at p33 in cycle t+2, with post_href=1.
  - Centre p22 = pixel (x-1, y-1).
  - No right/bottom replicate; downstream discards or pads.
- vsync rising mid-line: line_cnt=0 immediately; line-delay contents are not flushed, and the gating hides them.
- Lines shorter or longer than IMG_WIDTH, or href gaps inside a line: unsupported, and output is undefined until the next frame.
- Reset mid-frame: everything returns to reset values and the next frame proceeds normally.
- Line-delay pointer wraps from IMG_WIDTH-1 to 0; width is $clog2(IMG_WIDTH).

Decomposition:
- Shared vp_pkg: DATA_WIDTH default, IMG_WIDTH default, WIN_LATENCY=2 constant.
- One sub-module: line_delay (params DATA_WIDTH, IMG_WIDTH; ports clk, rst_n, ce, d, q).
  - Behaviour: a RAM with a single pointer, read-before-write on ce, q registered.
  - Instantiated twice, A and B in series.

Test Plan:
Use IMG_WIDTH=8, DATA_WIDTH=8, pixel = {y[3:0], x[3:0]}, 1 idle cycle between lines.
1. Line 0, x=5 (0x05) -> 2 cycles later p31=0x03, p32=0x04, p33=0x05; rows 1-2 all 0; post_href=1.
2. Line 2, x=3 (0x23) -> p11=0x01, p12=0x02, p13=0x03, p21=0x11, p22=0x12, p23=0x13, p31=0x21, p32=0x22, p33=0x23.
3. Line 3, x=0 (0x30) -> p11=p12=p21=p22=p31=p32=0; p13=0x10, p23=0x20, p33=0x30.
4. Second frame after vsync pulse, line 0, x=4 -> rows 1-2 all 0 despite stale RAM data; p33=0x04.
5. rst_n low mid-line 2 for 1 cycle, then a new frame -> all outputs 0 during reset; next frame line 1 shows row 1 = 0 and row 2 = line-0 data.
6. Between lines (href low) -> post_href=0 two cycles after href falls, and all p** = 0.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared constants for the video-pipeline filter front end.
package vp_pkg;
    localparam int VP_DATA_WIDTH = 8;
    localparam int VP_IMG_WIDTH  = 1280;
    localparam int WIN_LATENCY   = 2;
endpackage

// File: rtl/line_delay.sv
// Single-pointer RAM delay line: read-before-write on ce, registered output.
module line_delay
    import vp_pkg::*;
#(
    parameter int DATA_WIDTH = VP_DATA_WIDTH,
    parameter int IMG_WIDTH  = VP_IMG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    localparam int PTR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(IMG_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];
    logic [PTR_W-1:0]      ptr;

    // Contents are never reset; downstream gating hides stale data.
    always_ff @(posedge clk) begin
        if (ce) mem[ptr] <= d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            q   <= '0;
        end else if (ce) begin
            q   <= mem[ptr];
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end
endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood generator from a raster pixel stream, zero-padded at the
// top and left frame borders, with href/vsync delayed to match the window.
module matrix_3x3_gen
    import vp_pkg::*;
#(
    parameter int DATA_WIDTH = VP_DATA_WIDTH,
    parameter int IMG_WIDTH  = VP_IMG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pre_vsync,
    input  logic                  pre_href,
    input  logic [DATA_WIDTH-1:0] pre_data,
    output logic                  post_vsync,
    output logic                  post_href,
    output logic [DATA_WIDTH-1:0] p11,
    output logic [DATA_WIDTH-1:0] p12,
    output logic [DATA_WIDTH-1:0] p13,
    output logic [DATA_WIDTH-1:0] p21,
    output logic [DATA_WIDTH-1:0] p22,
    output logic [DATA_WIDTH-1:0] p23,
    output logic [DATA_WIDTH-1:0] p31,
    output logic [DATA_WIDTH-1:0] p32,
    output logic [DATA_WIDTH-1:0] p33
);
    logic [WIN_LATENCY:1]  href_pipe, vsync_pipe;
    logic [1:0]            line_cnt;
    logic [DATA_WIDTH-1:0] row3_tap, a_q, b_q;
    logic [2:0][DATA_WIDTH-1:0]      tap;
    logic [2:0][2:0][DATA_WIDTH-1:0] win;
    logic                  vs_rise, href_fall;

    assign vs_rise   = pre_vsync & ~vsync_pipe[1];
    assign href_fall = href_pipe[1] & ~pre_href;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_pipe  <= '0;
            vsync_pipe <= '0;
            line_cnt   <= '0;
            row3_tap   <= '0;
        end else begin
            href_pipe  <= {href_pipe[WIN_LATENCY-1:1], pre_href};
            vsync_pipe <= {vsync_pipe[WIN_LATENCY-1:1], pre_vsync};
            if (vs_rise)
                line_cnt <= '0;
            else if (href_fall && line_cnt != 2'd2)
                line_cnt <= line_cnt + 2'd1;
            if (pre_href) row3_tap <= pre_data;
        end
    end

    line_delay #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH)) u_line_a (
        .clk(clk), .rst_n(rst_n), .ce(pre_href), .d(pre_data), .q(a_q)
    );

    // A's q holds between enables, so it already lags one entry; B is one
    // entry shorter to keep row 1 column-aligned with rows 2 and 3.
    line_delay #(.DATA_WIDTH(DATA_WIDTH), .IMG_WIDTH(IMG_WIDTH - 1)) u_line_b (
        .clk(clk), .rst_n(rst_n), .ce(pre_href), .d(a_q), .q(b_q)
    );

    always_comb begin
        tap    = '0;
        tap[2] = row3_tap;
        if (line_cnt >= 2'd1) tap[1] = a_q;
        if (line_cnt >= 2'd2) tap[0] = b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (href_pipe[1]) begin
            for (int r = 0; r < 3; r++) begin
                win[r][2] <= tap[r];
                win[r][1] <= win[r][2];
                win[r][0] <= win[r][1];
            end
        end else begin
            win <= '0;
        end
    end

    assign post_href  = href_pipe[WIN_LATENCY];
    assign post_vsync = vsync_pipe[WIN_LATENCY];
    assign p11 = win[0][0];
    assign p12 = win[0][1];
    assign p13 = win[0][2];
    assign p21 = win[1][0];
    assign p22 = win[1][1];
    assign p23 = win[1][2];
    assign p31 = win[2][0];
    assign p32 = win[2][1];
    assign p33 = win[2][2];
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen with a frame-buffer reference model.
module tb_matrix_3x3_gen;
    localparam int DW = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pre_vsync = 1'b0;
    logic          pre_href = 1'b0;
    logic [DW-1:0] pre_data = '0;
    logic          post_vsync, post_href;
    logic [DW-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

    matrix_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .pre_vsync(pre_vsync), .pre_href(pre_href),
        .pre_data(pre_data), .post_vsync(post_vsync), .post_href(post_href),
        .p11(p11), .p12(p12), .p13(p13), .p21(p21), .p22(p22), .p23(p23),
        .p31(p31), .p32(p32), .p33(p33)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m1 = -100, m2 = -100, m3 = -100, m4 = -100, m5 = -100, m6 = -100;

    // Reference: the frame as received, indexed [line][column].
    int fm [16][8];
    int my = 0, mx = 0;
    bit vs_prev = 0, hr_prev = 0;
    int em [9];
    int ec [9];
    bit emh = 0, emv = 0, ech = 0, ecv = 0;
    int zero9 [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    function automatic int px(int r, int c);
        if (r < 0 || c < 0 || r > 15 || c > 7) return 0;
        return fm[r][c];
    endfunction

    function automatic string fmt9(int a [9]);
        return $sformatf("%02h %02h %02h | %02h %02h %02h | %02h %02h %02h",
                         a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[7], a[8]);
    endfunction

    function automatic void dut_win(output int g [9]);
        g = '{int'(p11), int'(p12), int'(p13), int'(p21), int'(p22), int'(p23),
              int'(p31), int'(p32), int'(p33)};
    endfunction

    task automatic lit(input string nm, input int e [9], input bit eh);
        int g [9];
        dut_win(g);
        checks++;
        if (g != e || post_href != eh) begin
            failures++;
            $display("FAIL %s got win=[%s] href=%0b exp win=[%s] href=%0b",
                     nm, fmt9(g), post_href, fmt9(e), eh);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            my = 0; mx = 0; vs_prev = 0; hr_prev = 0;
            em = zero9; ec = zero9;
            emh = 0; emv = 0; ech = 0; ecv = 0;
        end else begin
            ec = em; ech = emh; ecv = emv;
            if (pre_vsync && !vs_prev) my = 0;
            else if (hr_prev && !pre_href && my < 15) my++;
            if (pre_href) begin
                if (mx < 8) fm[my][mx] = int'(pre_data);
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        em[r*3+c] = px(my - 2 + r, mx - 2 + c);
                mx++;
            end else begin
                mx = 0;
                em = zero9;
            end
            emh = pre_href; emv = pre_vsync;
            vs_prev = pre_vsync; hr_prev = pre_href;
        end
    end

    initial forever begin
        int g [9];
        @(negedge clk);
        dut_win(g);
        checks++;
        if (g != ec || post_href != ech || post_vsync != ecv) begin
            failures++;
            $display("FAIL model cyc=%0d got win=[%s] h=%0b v=%0b exp win=[%s] h=%0b v=%0b",
                     cyc, fmt9(g), post_href, post_vsync, fmt9(ec), ech, ecv);
        end
        if (cyc == m1 + 2) lit("t1_line0_x5", '{0, 0, 0, 0, 0, 0, 'h03, 'h04, 'h05}, 1);
        if (cyc == m2 + 2) lit("t2_line2_x3", '{'h01, 'h02, 'h03, 'h11, 'h12, 'h13, 'h21, 'h22, 'h23}, 1);
        if (cyc == m3 + 2) lit("t3_line3_x0", '{0, 0, 'h10, 0, 0, 'h20, 0, 0, 'h30}, 1);
        if (cyc == m4 + 2) lit("t4_frame2_x4", '{0, 0, 0, 0, 0, 0, 'h02, 'h03, 'h04}, 1);
        if (cyc == m5 + 2) lit("t5_after_rst", '{0, 0, 0, 'h01, 'h02, 'h03, 'h11, 'h12, 'h13}, 1);
        if (cyc == m6 + 2) lit("t6_idle", zero9, 0);
    end

    task automatic drive(input logic vs, input logic hr, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        pre_vsync = vs;
        pre_href  = hr;
        pre_data  = d;
    endtask

    task automatic vsync_pulse();
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
    endtask

    task automatic send_line(input int y, output int s);
        s = 0;
        for (int x = 0; x < IW; x++) begin
            drive(0, 1, DW'((y << 4) | x));
            if (x == 0) s = cyc;
        end
        drive(0, 0, 0);
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        lit("reset_init", zero9, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);

        vsync_pulse();
        send_line(0, s); m1 = s + 5; m6 = s + IW;
        send_line(1, s);
        send_line(2, s); m2 = s + 3;
        send_line(3, s); m3 = s;

        vsync_pulse();
        send_line(0, s); m4 = s + 4;
        send_line(1, s);
        for (int x = 0; x < 4; x++) drive(0, 1, DW'(8'h20 | x));
        @(posedge clk);
        #1;
        rst_n = 1'b0; pre_href = 1'b0; pre_data = '0;
        @(negedge clk);
        lit("reset_mid", zero9, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);

        vsync_pulse();
        send_line(0, s);
        send_line(1, s); m5 = s + 3;
        repeat (4) drive(0, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
